// File: rtl/if_stage.sv
// Instruction-fetch stage: issues sequential word fetches under a credit limit,
// buffers in-order responses in a small FIFO and applies decode redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ID_stall_i,
  input  logic        ID_pc_src_i,
  input  logic [31:0] ID_branch_addr_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic [31:0] IF_Instruction_o,
  output logic [31:0] IF_PC_o,
  output logic        IF_valid_o
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = PW + 2;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_buf_q    [FIFO_DEPTH];
  logic [31:0]   instr_buf_q [FIFO_DEPTH];

  logic          head_valid;
  logic          pop;
  logic          push;
  logic          fire;
  logic          rsp_take;
  logic [CW-1:0] credit_used;

  assign head_valid = (count_q != '0);
  assign pop        = head_valid & ~ID_stall_i;

  // Slots already claimed by in-flight fetches plus buffered entries, net of
  // the entry decode takes this cycle; a new fetch needs a free slot.
  assign credit_used      = outst_q + count_q - CW'(pop);
  assign imem_req_valid_o = ~rst_i & ~ID_pc_src_i & (credit_used < DEPTH_C);
  assign imem_req_addr_o  = fetch_pc_q;
  assign fire             = imem_req_valid_o & imem_req_ready_i;
  assign rsp_take         = imem_rsp_valid_i & (outst_q != '0);

  assign IF_valid_o       = head_valid;
  assign IF_Instruction_o = head_valid ? instr_buf_q[rd_ptr_q] : NOP;
  assign IF_PC_o          = head_valid ? pc_buf_q[rd_ptr_q] : 32'h0000_0000;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + CW'(fire) - CW'(rsp_take);
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    push       = 1'b0;

    if (ID_pc_src_i) begin
      // Everything still in flight after this cycle's response is stale.
      fetch_pc_d = ID_branch_addr_i & 32'hFFFF_FFFC;
      resp_pc_d  = ID_branch_addr_i & 32'hFFFF_FFFC;
      drop_d     = outst_q - CW'(rsp_take);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_take) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + 32'd4;
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage needs no reset: count_q alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_buf_q[wr_ptr_q]    <= resp_pc_q;
      instr_buf_q[wr_ptr_q] <= imem_rsp_data_i;
    end
  end

endmodule
